// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared constants, types and helpers for the RSA job arbiter
//
// Contents: RSA_WIDTH (default operand width), rsa_state_t (arbiter FSM states),
//           req_idx_t (requester index), idx_to_mask (index -> one-hot ack mask).
package rsa_pkg;

    localparam int RSA_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } rsa_state_t;

    // Two requesters, so a single bit names one of them.
    typedef logic req_idx_t;

    function automatic logic [1:0] idx_to_mask(input req_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant selection
//
// Ports: req[1:0]    request bits from requesters 0 and 1
//        last_grant  requester granted most recently
//        grant_valid at least one request is present
//        grant       chosen requester (meaningful only with grant_valid)
module rr_arbiter2
    import rsa_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   last_grant,
    output logic       grant_valid,
    output req_idx_t   grant
);

    always_comb begin
        grant_valid = |req;
        grant       = last_grant;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            // On a tie the requester that was not served last goes next.
            2'b11:   grant = ~last_grant;
            default: grant = last_grant;
        endcase
    end

endmodule

// File: rtl/rsa_job_arbiter.sv
// rtl/rsa_job_arbiter.sv - two-port round-robin job front end for a shared modexp engine
//
// Ports: clk, rst           single clock, synchronous active-high reset
//        req[1:0]           job request per requester
//        n_in, b_in, c_in   per-requester N/B/C, slice i belongs to requester i
//        ack[1:0]           one-cycle completion pulse to the served requester
//        result, err        job outcome, valid while ack is nonzero, held otherwise
//        eng_start          one-cycle start pulse to the engine
//        eng_n/eng_b/eng_c  latched operands, stable through ISSUE and WAIT
//        eng_done           engine completion pulse (only honoured in WAIT)
//        eng_result         engine result, valid with eng_done
// Optional build: define RSA_ARB_TIMEOUT_EN to add a WAIT watchdog of
// TIMEOUT_CYCLES cycles that finishes the job with err=1 and result=0.
module rsa_job_arbiter
    import rsa_pkg::*;
#(
    parameter int WIDTH          = RSA_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [2*WIDTH-1:0] n_in,
    input  logic [2*WIDTH-1:0] b_in,
    input  logic [2*WIDTH-1:0] c_in,
    output logic [1:0]         ack,
    output logic [WIDTH-1:0]   result,
    output logic               err,
    output logic               eng_start,
    output logic [WIDTH-1:0]   eng_n,
    output logic [WIDTH-1:0]   eng_b,
    output logic [WIDTH-1:0]   eng_c,
    input  logic               eng_done,
    input  logic [WIDTH-1:0]   eng_result
);

    rsa_state_t state;
    req_idx_t   last_grant;   // also identifies the job in flight
    logic       grant_valid;
    req_idx_t   grant_idx;

    rr_arbiter2 u_rr (
        .req         (req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant_idx)
    );

`ifdef RSA_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] wait_cnt;
    logic             err_q;

    assign err = err_q;
`else
    // Watchdog compiled out; TIMEOUT_CYCLES has no effect in this build.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end

    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;   // port 0 wins the first tie after reset
            ack        <= '0;
            eng_start  <= 1'b0;
            result     <= '0;
            eng_n      <= '0;
            eng_b      <= '0;
            eng_c      <= '0;
`ifdef RSA_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            ack       <= '0;
            eng_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        last_grant <= grant_idx;
                        eng_n      <= grant_idx ? n_in[2*WIDTH-1:WIDTH] : n_in[WIDTH-1:0];
                        eng_b      <= grant_idx ? b_in[2*WIDTH-1:WIDTH] : b_in[WIDTH-1:0];
                        eng_c      <= grant_idx ? c_in[2*WIDTH-1:WIDTH] : c_in[WIDTH-1:0];
                        eng_start  <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef RSA_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        result <= eng_result;
                        ack    <= idx_to_mask(last_grant);
`ifdef RSA_ARB_TIMEOUT_EN
                        err_q  <= 1'b0;
`endif
                        state  <= ST_RESP;
                    end
`ifdef RSA_ARB_TIMEOUT_EN
                    // wait_cnt counts completed WAIT cycles; this is the last allowed one.
                    else if (wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        result <= '0;
                        err_q  <= 1'b1;
                        ack    <= idx_to_mask(last_grant);
                        state  <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
